// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command-table write sequencer.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, CTRL, ACK_C, DATA, ACK_D, STOP, GAP, DONE, ERR
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int unsigned BYTE_BITS = 8;

    // Bits needed to hold the values 0..max_val (at least one).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/i2c_cmd_seq_if.sv
// Table-ROM, pad and status signals of the I2C command sequencer.
interface i2c_cmd_seq_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic [7:0]        cmd_data;
    logic [ADDR_W-1:0] cmd_address;
    logic              sda_in;
    logic              scl_in;
    logic              sda_oe;
    logic              scl_oe;
    logic              busy;
    logic              done;
    logic              nack_err;

    modport master (
        input  start, cmd_data, sda_in, scl_in,
        output cmd_address, sda_oe, scl_oe, busy, done, nack_err
    );

    modport slave (
        output start, cmd_data, sda_in, scl_in,
        input  cmd_address, sda_oe, scl_oe, busy, done, nack_err
    );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: CLK_DIV clk2 cycles per quarter, four quarters per bit slot.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk2,
    input  logic       reset,
    input  logic       en,
    input  logic       stretch_hold,
    output logic [1:0] q,
    output logic       q_end,
    output logic       sample
);

    localparam int unsigned DW = cnt_width(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    q_q, q_d;

    always_comb begin
        div_d  = div_q;
        q_d    = q_q;
        q_end  = en && !stretch_hold && (div_q == DIV_LAST);
        sample = q_end && (q_q == Q2);
        if (!en) begin
            div_d = '0;
            q_d   = Q0;
        end else if (!stretch_hold) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                q_d   = q_q + 2'd1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            q_q   <= Q0;
        end else begin
            div_q <= div_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/i2c_cmd_seq.sv
// Walks a command ROM, sending each entry as START/addr/ctrl/data/STOP with
// NACK retry and clock-stretch tolerance; drives open-drain pad enables.
module i2c_cmd_seq
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h3D,
    parameter logic [7:0]  CTRL_BYTE  = 8'h00,
    parameter int unsigned NUM_CMDS   = 40,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic          clk2,
    input  logic          reset,
    i2c_cmd_seq_if.master bus
);

    localparam int unsigned       RW        = cnt_width(MAX_RETRY);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CMDS - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(BYTE_BITS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              nack_q, nack_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              nack_err_q, nack_err_d;
    logic              sda_oe_q, sda_oe_d;
    logic              scl_oe_q, scl_oe_d;

    logic [1:0] q, q_nxt;
    logic       q_end, sample, slot_end, stretch_hold;

    assign stretch_hold = (q == Q2) && !bus.scl_in;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk2        (clk2),
        .reset       (reset),
        .en          (busy_q),
        .stretch_hold(stretch_hold),
        .q           (q),
        .q_end       (q_end),
        .sample      (sample)
    );

    assign slot_end = q_end && (q == Q3);
    assign q_nxt    = q_end ? q + 2'd1 : q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        retry_d    = retry_q;
        nack_d     = nack_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        busy_d     = busy_q;
        done_d     = done_q;
        nack_err_d = nack_err_q;
        sda_oe_d   = 1'b0;
        scl_oe_d   = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d    = START;
                    addr_d     = '0;
                    retry_d    = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    nack_err_d = 1'b0;
                end
            end
            START: begin
                if (slot_end) begin
                    state_d = ADDR;
                    bit_d   = '0;
                    sh_d    = {SLAVE_ADDR, 1'b0};
                end
            end
            ADDR, CTRL, DATA: begin
                if (slot_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = (state_q == ADDR) ? ACK_A :
                                  (state_q == CTRL) ? ACK_C : ACK_D;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                    end
                end
            end
            ACK_A, ACK_C, ACK_D: begin
                if (sample) nack_d = bus.sda_in;
                if (slot_end) begin
                    bit_d = '0;
                    if (nack_q || state_q == ACK_D) begin
                        state_d = STOP;
                    end else if (state_q == ACK_A) begin
                        state_d = CTRL;
                        sh_d    = CTRL_BYTE;
                    end else begin
                        // ROM byte is latched here, at the first DATA bit boundary
                        state_d = DATA;
                        sh_d    = bus.cmd_data;
                    end
                end
            end
            STOP: begin
                if (slot_end) state_d = GAP;
            end
            GAP: begin
                if (slot_end) begin
                    if (nack_q) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d = retry_q + RW'(1);
                            state_d = START;
                        end else begin
                            state_d    = ERR;
                            busy_d     = 1'b0;
                            nack_err_d = 1'b1;
                        end
                    end else begin
                        retry_d = '0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = START;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Pad enables are registered from the next state/quarter so they switch
        // on the same edge as the slot boundary without decode glitches.
        case (state_d)
            START:            sda_oe_d = q_nxt[1];
            ADDR, CTRL, DATA: begin
                sda_oe_d = !sh_d[7];
                scl_oe_d = !q_nxt[1];
            end
            ACK_A, ACK_C, ACK_D: scl_oe_d = !q_nxt[1];
            STOP: begin
                sda_oe_d = (q_nxt == Q0) || (q_nxt == Q1);
                scl_oe_d = (q_nxt == Q0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            retry_q    <= '0;
            nack_q     <= 1'b0;
            bit_q      <= '0;
            sh_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            retry_q    <= retry_d;
            nack_q     <= nack_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_err_q <= nack_err_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
        end
    end

    assign bus.cmd_address = addr_q;
    assign bus.sda_oe      = sda_oe_q;
    assign bus.scl_oe      = scl_oe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.nack_err    = nack_err_q;

endmodule

// File: doc/i2c_cmd_seq.md
Name: i2c_cmd_seq

Overview:
Parametrised I2C write-sequencer and successor to the fixed 0x7A command/data writer. It walks a command table of NUM_CMDS bytes held in an external ROM. Each entry becomes one I2C write transaction: START, slave address+W, control byte, data byte, STOP. The block generates SCL from the single system clock and tolerates slave clock stretching. It retries NACKed transactions and reports busy, done and error status; it sits between the table ROM and the open-drain pad cells.

Parameters:
SLAVE_ADDR, 7'h3D, 7-bit slave address; R/W bit is always 0, so the wire byte is 8'h7A.
CTRL_BYTE, 8'h00, control/mode byte sent after the address.
NUM_CMDS, 40, number of table entries per run (1..2**ADDR_W).
ADDR_W, 7, width of cmd_address.
CLK_DIV, 4, clk2 cycles per quarter-bit (>=2).
MAX_RETRY, 3, extra attempts per entry after a NACK (0..15).

Ports:
clk2  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run at entry 0
cmd_data  in  8  table byte for cmd_address (combinational ROM)
cmd_address  out  ADDR_W  current table index
sda_in  in  1  SDA pad input (synchronised externally)
scl_in  in  1  SCL pad input, used for stretch detection
sda_oe  out  1  1 = pull SDA low, 0 = release
scl_oe  out  1  1 = pull SCL low, 0 = release
busy  out  1  run in progress
done  out  1  sticky; all entries ACKed; cleared by start
nack_err  out  1  sticky; retries exhausted; cleared by start

Behaviour:
- Reset (async): sda_oe=0, scl_oe=0, busy=0, done=0, nack_err=0, cmd_address=0, retry counter=0, FSM=IDLE, quarter counter=0.
- Bit timing: every bit slot is 4 quarters (q0..q3), and each quarter lasts CLK_DIV clk2 cycles.
- Data and ACK bits:
  - q0/q1: scl_oe=1; SDA is updated at the start of q0.
  - q2/q3: scl_oe=0.
  - sda_in is sampled on the last clk2 cycle of q2.
- Clock stretching: during q2 the quarter counter holds while scl_in=0. The q2 count starts only once scl_in=1.
- START slot: q0/q1 SDA released and SCL released; q2/q3 sda_oe=1 with SCL released; SCL is pulled low entering the next slot.
- STOP slot:
  - q0: sda_oe=1, scl_oe=1.
  - q1: sda_oe=1, scl_oe=0.
  - q2/q3: sda_oe=0, scl_oe=0.
- GAP slot: both lines released (bus-free time).
- Bytes are sent MSB first. During ACK slots sda_oe=0. ACK is sampled sda_in=0; NACK is sampled sda_in=1.
- FSM states: IDLE, START, ADDR, ACK_A, CTRL, ACK_C, DATA, ACK_D, STOP, GAP, DONE, ERR.
  - IDLE/DONE/ERR + start → START. The same transition clears done/nack_err, sets cmd_address=0 and retry=0, and sets busy=1 on the next edge.
  - START → ADDR (8 bits of {SLAVE_ADDR,1'b0}) → ACK_A → CTRL (CTRL_BYTE) → ACK_C → DATA (cmd_data[7-i]) → ACK_D → STOP → GAP.
  - Any NACK → STOP, then the retry flag is set.
  - GAP end with success: retry=0. If cmd_address==NUM_CMDS-1 → DONE (busy=0, done=1); else cmd_address+1 → START.
  - GAP end after a NACK:
    - retry<MAX_RETRY: retry+1, cmd_address unchanged → START.
    - Otherwise → ERR (busy=0, nack_err=1, cmd_address frozen at the failing entry).
- cmd_data is sampled once, at the q0 boundary of the first DATA bit, into a shift register. ROM latency must be ≤ 1 byte time.
- start while busy=1 is ignored.
- Unstretched timing: one transaction = 30 slots = 120*CLK_DIV clk2 cycles. start → first SDA fall = 2*CLK_DIV+1 cycles.
- Reset mid-transaction releases both lines immediately. No STOP is generated.
- Unused FSM encodings → IDLE with lines released.

Decomposition:
- Package i2c_pkg holds:
  - the state enum;
  - quarter indices Q0..Q3;
  - slot bit counts (BYTE_BITS=8);
  - the counter-width helper for CLK_DIV and MAX_RETRY.
- One sub-module, i2c_tick_gen, contains the CLK_DIV divider and quarter counter. It takes inputs en and stretch_hold, and outputs q (2 bits), q_end and sample.

Test Plan:
- NUM_CMDS=3, CLK_DIV=4, ROM={8'hA5,8'h3C,8'hFF}, model always ACKs.
  - Required: decoded bytes 7A,00,A5 / 7A,00,3C / 7A,00,FF.
  - done=1 at exactly 3*480 cycles + start latency; cmd_address ends at 2.
- NACK on ACK_C of entry 1, once.
  - Required: STOP and GAP, then entry 1 is resent with cmd_address still 1; run completes with done=1 and nack_err=0.
- Persistent NACK on ACK_A of entry 0 with MAX_RETRY=3.
  - Required: exactly 4 START conditions, then nack_err=1, busy=0, cmd_address=0.
  - A subsequent start clears nack_err.
- Slave holds scl_in=0 for 37 cycles at ACK_D q2.
  - Required: SDA and sample timing shift by exactly 37 cycles, with no extra bit.
- reset asserted during the DATA bit 3.
  - Required: sda_oe=0 and scl_oe=0 asynchronously, all status outputs 0, cmd_address=0.
- start pulse while busy.
  - Required: no change in the bit stream; cmd_address sequence unchanged.
